// File: rtl/playback_controller.sv
// -----------------------------------------------------------------------------
// playback_controller
//
// Command stage in front of the flash audio driver. It decodes ASCII keyboard
// commands and the three speed pushbuttons into the driver's enable, reverse
// and count (divider period) inputs. It also generates a restart pulse that
// sends the fetcher's address back to the start or end of the song.
//
// Optional feature macro: BTN_DEBOUNCE_EN
//   defined   : every button passes through a debounce counter of
//               DEBOUNCE_CYCLES stable cycles before edge detection.
//   undefined : edges are taken straight from the synchronised inputs.
//
// Ports
//   clk_i          system clock (50 MHz)
//   reset_i        asynchronous reset, active low
//   key_valid_i    one-cycle strobe, key_code_i is valid this cycle
//   key_code_i     ASCII command byte (E/D/F/B/R, case-insensitive)
//   speed_up_i     button level, active high, synchronised to clk_i
//   speed_down_i   button level, active high, synchronised to clk_i
//   speed_reset_i  button level, active high, synchronised to clk_i
//   enable_o       driver enable (playback running)
//   reverse_o      driver direction, 1 = backward
//   count_o        driver divider count
//   restart_o      fetcher restart, active high
//   state_dbg_o    current FSM state encoding (debug only)
//
// States
//   state      | meaning
//   ST_STOP    | playback halted, enable low
//   ST_PLAY    | playback running, enable high
//   ST_RESTART | restart pulse high for RESTART_CYCLES, then back to
//              | PLAY or STOP depending on run_saved
// -----------------------------------------------------------------------------
module playback_controller #(
    parameter int WIDTH           = 16,
    parameter int COUNT_DEFAULT   = 2272,
    parameter int COUNT_STEP      = 64,
    parameter int COUNT_MIN       = 568,
    parameter int COUNT_MAX       = 9088,
    parameter int RESTART_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             key_valid_i,
    input  logic [7:0]       key_code_i,
    input  logic             speed_up_i,
    input  logic             speed_down_i,
    input  logic             speed_reset_i,
    output logic             enable_o,
    output logic             reverse_o,
    output logic [WIDTH-1:0] count_o,
    output logic             restart_o,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_RESTART = 2'b10
    } state_t;

    localparam int RCW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [RCW-1:0] RC_LOAD = RCW'(RESTART_CYCLES - 1);

    localparam logic [WIDTH-1:0] CNT_DEF = WIDTH'(COUNT_DEFAULT);
    localparam logic [WIDTH-1:0] CNT_MIN = WIDTH'(COUNT_MIN);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(COUNT_MAX);
    localparam logic [WIDTH:0]   CNT_STP = (WIDTH+1)'(COUNT_STEP);

    // Elaboration-time sanity check of the parameter set.
    if (COUNT_MIN > COUNT_MAX || COUNT_DEFAULT < COUNT_MIN || COUNT_DEFAULT > COUNT_MAX ||
        COUNT_STEP < 1 || RESTART_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_cfg_bad
        $error("playback_controller: inconsistent parameter set");
    end

    // ------------------------------------------------------------------
    // Key decode: fold lower case onto upper case, then match.
    // ------------------------------------------------------------------
    logic [7:0] key_uc;
    logic       cmd_start, cmd_stop, cmd_fwd, cmd_back, cmd_restart;

    assign key_uc      = (key_code_i >= 8'h61 && key_code_i <= 8'h7A) ? (key_code_i - 8'h20)
                                                                       : key_code_i;
    assign cmd_start   = key_valid_i && (key_uc == 8'h45);  // 'E'
    assign cmd_stop    = key_valid_i && (key_uc == 8'h44);  // 'D'
    assign cmd_fwd     = key_valid_i && (key_uc == 8'h46);  // 'F'
    assign cmd_back    = key_valid_i && (key_uc == 8'h42);  // 'B'
    assign cmd_restart = key_valid_i && (key_uc == 8'h52);  // 'R'

    // ------------------------------------------------------------------
    // Button levels: bit 0 = up, bit 1 = down, bit 2 = reset
    // ------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] btn_lvl;

    assign btn_raw = {speed_reset_i, speed_down_i, speed_up_i};

`ifdef BTN_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LOAD = DBW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]     db_q;
    logic [DBW-1:0] dbc_q [3];

    // Down-counter per button: reloaded while the raw level matches the
    // accepted level, the new level is accepted when it reaches zero.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            db_q <= 3'b000;
            for (int i = 0; i < 3; i++) dbc_q[i] <= DB_LOAD;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_raw[i] == db_q[i]) begin
                    dbc_q[i] <= DB_LOAD;
                end else if (dbc_q[i] == '0) begin
                    db_q[i]  <= btn_raw[i];
                    dbc_q[i] <= DB_LOAD;
                end else begin
                    dbc_q[i] <= dbc_q[i] - DBW'(1);
                end
            end
        end
    end

    assign btn_lvl = db_q;
`else
    assign btn_lvl = btn_raw;
`endif

    // ------------------------------------------------------------------
    // Edge detection. armed_q suppresses the first cycle after reset so a
    // button held through reset release is not seen as a press.
    // ------------------------------------------------------------------
    logic [2:0] btn_prev_q;
    logic       armed_q;
    logic [2:0] btn_edge;

    assign btn_edge = armed_q ? (btn_lvl & ~btn_prev_q) : 3'b000;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             run_saved_q, run_saved_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             enable_q, enable_d;
    logic             restart_q, restart_d;
    logic             reverse_q, reverse_d;
    logic [WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_STOP;
            run_saved_q <= 1'b0;
            rcnt_q      <= '0;
            enable_q    <= 1'b0;
            restart_q   <= 1'b0;
            reverse_q   <= 1'b0;
            count_q     <= CNT_DEF;
            btn_prev_q  <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_saved_q <= run_saved_d;
            rcnt_q      <= rcnt_d;
            enable_q    <= enable_d;
            restart_q   <= restart_d;
            reverse_q   <= reverse_d;
            count_q     <= count_d;
            btn_prev_q  <= btn_lvl;
            armed_q     <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        run_saved_d = run_saved_q;
        rcnt_d      = rcnt_q;

        case (state_q)
            ST_STOP: begin
                if (cmd_start) begin
                    state_d = ST_PLAY;
                end else if (cmd_restart) begin
                    state_d     = ST_RESTART;
                    rcnt_d      = RC_LOAD;
                    run_saved_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (cmd_stop) begin
                    state_d = ST_STOP;
                end else if (cmd_restart) begin
                    state_d     = ST_RESTART;
                    rcnt_d      = RC_LOAD;
                    run_saved_d = 1'b1;
                end
            end
            ST_RESTART: begin
                // A fresh 'R' extends the pulse even on the terminal cycle.
                if (cmd_restart) begin
                    rcnt_d = RC_LOAD;
                end else if (rcnt_q == '0) begin
                    state_d = run_saved_q ? ST_PLAY : ST_STOP;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
                if (cmd_start) run_saved_d = 1'b1;
                if (cmd_stop)  run_saved_d = 1'b0;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // Outputs are registered from the next state so they follow a key by one edge.
    assign enable_d  = (state_d == ST_PLAY);
    assign restart_d = (state_d == ST_RESTART);

    // ------------------------------------------------------------------
    // Direction
    // ------------------------------------------------------------------
    always_comb begin
        reverse_d = reverse_q;
        if (cmd_back)     reverse_d = 1'b1;
        else if (cmd_fwd) reverse_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Speed count, arithmetic one bit wider than the count so the
    // borrow/carry is visible before clamping.
    // ------------------------------------------------------------------
    logic [WIDTH:0] cnt_dec;
    logic [WIDTH:0] cnt_inc;

    assign cnt_dec = {1'b0, count_q} - CNT_STP;
    assign cnt_inc = {1'b0, count_q} + CNT_STP;

    always_comb begin
        count_d = count_q;
        if (btn_edge[2]) begin
            count_d = CNT_DEF;
        end else if (btn_edge[0] && btn_edge[1]) begin
            count_d = count_q;
        end else if (btn_edge[0]) begin
            if (cnt_dec[WIDTH] || (cnt_dec < {1'b0, CNT_MIN})) count_d = CNT_MIN;
            else                                                 count_d = cnt_dec[WIDTH-1:0];
        end else if (btn_edge[1]) begin
            if (cnt_inc > {1'b0, CNT_MAX}) count_d = CNT_MAX;
            else                           count_d = cnt_inc[WIDTH-1:0];
        end
    end

    assign enable_o    = enable_q;
    assign reverse_o   = reverse_q;
    assign count_o     = count_q;
    assign restart_o   = restart_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_playback_controller.sv
module tb_playback_controller;

    localparam int WIDTH = 16;
    localparam int DEF   = 2272;
    localparam int STEP  = 64;
    localparam int MINC  = 568;
    localparam int MAXC  = 9088;
    localparam int RC    = 4;
    localparam int DB    = 8;
`ifdef BTN_DEBOUNCE_EN
    localparam int HOLD  = DB + 2;
`else
    localparam int HOLD  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             kv = 1'b0;
    logic [7:0]       kc = 8'h00;
    logic             up = 1'b0, dn = 1'b0, sr = 1'b0;
    logic             enable, reverse, restart;
    logic [WIDTH-1:0] count;
    logic [1:0]       state_dbg;

    always #10 clk = ~clk;

    playback_controller #(
        .WIDTH(WIDTH), .COUNT_DEFAULT(DEF), .COUNT_STEP(STEP), .COUNT_MIN(MINC),
        .COUNT_MAX(MAXC), .RESTART_CYCLES(RC), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_i(clk), .reset_i(rst_n), .key_valid_i(kv), .key_code_i(kc),
        .speed_up_i(up), .speed_down_i(dn), .speed_reset_i(sr),
        .enable_o(enable), .reverse_o(reverse), .count_o(count),
        .restart_o(restart), .state_dbg_o(state_dbg)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        rev;
        logic        rs;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_st, m_run, m_rc, m_rev, m_cnt;
    bit         m_armed;
    logic [2:0] m_prev;
    logic [2:0] m_db;
    int         m_dc[3];

    task automatic model_reset();
        m_st = 0; m_run = 0; m_rc = 0; m_rev = 0; m_cnt = DEF;
        m_armed = 0; m_prev = 3'b000; m_db = 3'b000;
        for (int i = 0; i < 3; i++) m_dc[i] = DB - 1;
    endtask

    task automatic model_step(output exp_t e);
        logic [7:0] c;
        logic [2:0] raw, lvl, edg;
        bit kE, kD, kF, kB, kR;
        int nst, nrun, nrc;
        if (!rst_n) begin
            model_reset();
        end else begin
            c = kc;
            if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
            kE = kv && c == 8'h45; kD = kv && c == 8'h44; kF = kv && c == 8'h46;
            kB = kv && c == 8'h42; kR = kv && c == 8'h52;
            raw = {sr, dn, up};
`ifdef BTN_DEBOUNCE_EN
            lvl = m_db;
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == m_db[i]) m_dc[i] = DB - 1;
                else if (m_dc[i] == 0) begin m_db[i] = raw[i]; m_dc[i] = DB - 1; end
                else m_dc[i] = m_dc[i] - 1;
            end
`else
            lvl = raw;
`endif
            edg = m_armed ? (lvl & ~m_prev) : 3'b000;
            nst = m_st; nrun = m_run; nrc = m_rc;
            case (m_st)
                0: if (kE) nst = 1; else if (kR) begin nst = 2; nrc = RC - 1; nrun = 0; end
                1: if (kD) nst = 0; else if (kR) begin nst = 2; nrc = RC - 1; nrun = 1; end
                default: begin
                    if (kR) nrc = RC - 1;
                    else if (m_rc == 0) nst = m_run ? 1 : 0;
                    else nrc = m_rc - 1;
                    if (kE) nrun = 1;
                    if (kD) nrun = 0;
                end
            endcase
            m_st = nst; m_run = nrun; m_rc = nrc;
            if (kB) m_rev = 1; else if (kF) m_rev = 0;
            if (edg[2]) m_cnt = DEF;
            else if (edg[0] && edg[1]) m_cnt = m_cnt;
            else if (edg[0]) m_cnt = (m_cnt - STEP < MINC) ? MINC : m_cnt - STEP;
            else if (edg[1]) m_cnt = (m_cnt + STEP > MAXC) ? MAXC : m_cnt + STEP;
            m_prev = lvl; m_armed = 1;
        end
        e.st  = 2'(m_st);
        e.en  = (m_st == 1);
        e.rev = m_rev[0];
        e.rs  = (m_st == 2);
        e.cnt = 16'(m_cnt);
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic cyc();
        exp_t e, got;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {state_dbg, enable, reverse, restart, count};
        e = sb_q.pop_front();
        check("sb_outputs", 32'(got), 32'(e));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic key(input logic [7:0] ch);
        kv = 1'b1; kc = ch;
        cyc();
        kv = 1'b0; kc = 8'h00;
    endtask

    task automatic btn(input logic [2:0] m);
        {sr, dn, up} = m;
    endtask

    task automatic press(input logic [2:0] m);
        btn(m); idle(HOLD);
        btn(3'b000); idle(HOLD);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable",  32'(enable),    32'd0);
        check("rst_reverse", 32'(reverse),   32'd0);
        check("rst_restart", 32'(restart),   32'd0);
        check("rst_count",   32'(count),     32'(DEF));
        check("rst_state",   32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // ignored keys: invalid strobe and unknown code
        kv = 1'b0; kc = "E"; cyc(); kc = 8'h00;
        key("X");
        check("ignored_state", 32'(state_dbg), 32'd0);

        // 1: start
        key("E");
        check("t1_enable", 32'(enable),    32'd1);
        check("t1_state",  32'(state_dbg), 32'd1);
        check("t1_count",  32'(count),     32'(DEF));

        // 2: direction
        key("b");
        check("t2_rev_back", 32'(reverse), 32'd1);
        check("t2_enable",   32'(enable),  32'd1);
        key("F");
        check("t2_rev_fwd",  32'(reverse), 32'd0);

        // 3: restart from PLAY and from STOP
        key("R");
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (restart) hi++;
            idle(1);
        end
        check("t3_pulse_len",   32'(hi),        32'(RC));
        check("t3_play_enable", 32'(enable),    32'd1);
        check("t3_play_state",  32'(state_dbg), 32'd1);
        key("d");
        key("r");
        idle(2);
        key("R");                // extend mid-pulse
        key("B");                // direction changes during RESTART
        check("t3_rev_in_rst", 32'(reverse), 32'd1);
        idle(6);
        check("t3_stop_state",  32'(state_dbg), 32'd0);
        check("t3_stop_enable", 32'(enable),    32'd0);
        key("f");

        // 4: saturate at the floor, then step back down
        repeat (26) press(3'b001);
        check("t4_count_26", 32'(count), 32'd608);
        press(3'b001);
        check("t4_count_min", 32'(count), 32'(MINC));
        repeat (3) press(3'b010);
        check("t4_count_760", 32'(count), 32'd760);

        // 5: simultaneous edges and held button
        btn(3'b011); idle(HOLD);
        check("t5_updown", 32'(count), 32'd760);
        btn(3'b000); idle(HOLD);
        btn(3'b111); idle(HOLD);
        check("t5_reset_wins", 32'(count), 32'(DEF));
        btn(3'b000); idle(HOLD);
        btn(3'b001); idle(100);
        check("t5_held", 32'(count), 32'(DEF - STEP));
        btn(3'b000); idle(HOLD);

        // ceiling saturation
        repeat (110) press(3'b010);
        check("t5_count_max", 32'(count), 32'(MAXC));

        // key and button in the same cycle
        kv = 1'b1; kc = "B"; up = 1'b1;
        cyc();
        kv = 1'b0; kc = 8'h00;
        check("t5_same_rev", 32'(reverse), 32'd1);
`ifndef BTN_DEBOUNCE_EN
        check("t5_same_cnt", 32'(count), 32'(MAXC - STEP));
`endif
        idle(HOLD);
        up = 1'b0; idle(HOLD);

        // 6: async reset during RESTART, button held through release
        key("e");
        key("R");
        idle(1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_restart", 32'(restart),   32'd0);
        check("t6_enable",  32'(enable),    32'd0);
        check("t6_count",   32'(count),     32'(DEF));
        check("t6_state",   32'(state_dbg), 32'd0);
        check("t6_reverse", 32'(reverse),   32'd0);
        model_reset();
        up = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(5);
`ifndef BTN_DEBOUNCE_EN
        check("t6_held_release", 32'(count), 32'(DEF));
`endif
        up = 1'b0;
        idle(HOLD + 2);

`ifdef BTN_DEBOUNCE_EN
        begin
            logic [15:0] before;
            before = count;
            up = 1'b1; idle(5);
            up = 1'b0; idle(DB + 4);
            check("t6_glitch", 32'(count), 32'(before));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
